// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the VGA timing controller:
//   - default 640x480@60 timing constants (pixels / lines per segment),
//   - derived totals and sync window bounds for the default mode,
//   - the controller state enum,
//   - a helper that sizes the pixel-rate divider register.
// ---------------------------------------------------------------------------
package vga_pkg;

    // Counter MSB index and pixel-rate divider for a 50 MHz board clock.
    localparam int unsigned DEF_N       = 9;
    localparam int unsigned DEF_CLK_DIV = 2;

    // Horizontal segments, in pixels.
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Vertical segments, in lines.
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Derived values for the default mode.
    localparam int unsigned DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // IDLE : counters held at (0,0), outputs blanked, sync inactive.
    // RUN  : scanning, en still asserted.
    // DRAIN: scanning, stop requested; returns to IDLE at the end of frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_t;

    // Width of a counter that must hold 0..div-1. A divide-by-one still
    // gets a single bit so the register is never zero-width.
    function automatic int unsigned div_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// ---------------------------------------------------------------------------
// vga_axis_seq
//
// One scan axis (horizontal or vertical): a wrapping position counter with
// step/clear controls plus sync and active-area decode of the *next* count.
// Decoding the next count lets the parent register sync/blank on the same
// edge as the counter, so position and decode never skew.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   step_i      advance by one position (wraps TOTAL-1 -> 0)
//   clear_i     force the counter to 0 (has priority over step_i)
//   cnt_o       current position, 0..TOTAL-1
//   wrap_o      step_i while at TOTAL-1: this step returns the axis to 0
//   sync_d_o    next position lies in [SYNC_START, SYNC_END)
//   active_d_o  next position lies in [0, ACTIVE)
// ---------------------------------------------------------------------------
module vga_axis_seq #(
    parameter int unsigned W          = 10,
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         step_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         sync_d_o,
    output logic         active_d_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;
    logic [31:0]  cnt_d_ext;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // wrap_o deliberately ignores clear_i: the vertical axis is chained off
    // the horizontal wrap, and the FSM needs the end-of-frame condition to
    // decide whether to clear in the first place.
    assign wrap_o = step_i & at_last;

    // Compare at 32 bits: SYNC_END may equal TOTAL when the back porch is
    // empty, which would not fit in W bits.
    assign cnt_d_ext  = 32'(cnt_d);
    assign sync_d_o   = (cnt_d_ext >= SYNC_START) && (cnt_d_ext < SYNC_END);
    assign active_d_o = (cnt_d_ext < ACTIVE);

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Single timing source for the VGA scan path. A free-running divider makes a
// pixel-rate tick from the system clock; an IDLE/RUN/DRAIN controller gates
// two chained axis counters so scanning always starts at (0,0) and a stop
// request always finishes the current frame. Sync, blank and the line/frame
// markers are registered from the next-state counters, so every output moves
// on the same clock edge as x/y.
//
// Run/stop handshake: en is a level request sampled only on tick cycles.
// en=1 on a tick starts (from IDLE) or keeps scanning; en=0 on a tick marks
// the frame to end, and the controller goes IDLE on the wrap tick of the
// last position only if en is still 0 there. Pulses of en between ticks are
// never seen.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run request (level, sampled on ticks)
//   pix_tick     one-clk pulse every CLK_DIV clks
//   x, y         scan position
//   hsync/vsync  active-low sync
//   blank        high outside the active area or while idle
//   line_start   one-clk pulse when x becomes 0 while running
//   frame_start  one-clk pulse when (x,y) becomes (0,0) while running
//   running      high in RUN and DRAIN
//   frame_cnt    frames started, modulo 256
// ---------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       pix_tick,
    output logic [N:0] x,
    output logic [N:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic       running,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned      DIV_W    = div_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // -----------------------------------------------------------------------
    // Pixel-rate divider. Free-runs regardless of state; tick is the
    // internal strobe, pix_tick its registered copy. Registering it makes
    // pix_tick rise on the same edge where the counters and state move, so
    // a consumer sees pix_tick together with the new x/y.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // -----------------------------------------------------------------------
    // Axis counters. The vertical axis steps on the horizontal wrap, so its
    // wrap output is the end-of-frame tick (tick & scanning & at last x,y).
    // -----------------------------------------------------------------------
    vga_state_t state_q;
    vga_state_t state_d;

    logic       h_step;
    logic       axis_clear;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_d;
    logic       v_sync_d;
    logic       h_active_d;
    logic       v_active_d;
    logic [N:0] h_cnt;
    logic [N:0] v_cnt;

    assign h_step     = tick && (state_q != IDLE);
    assign axis_clear = (state_d == IDLE);

    vga_axis_seq #(
        .W          (N + 1),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) u_h_axis (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .step_i     (h_step),
        .clear_i    (axis_clear),
        .cnt_o      (h_cnt),
        .wrap_o     (h_wrap),
        .sync_d_o   (h_sync_d),
        .active_d_o (h_active_d)
    );

    vga_axis_seq #(
        .W          (N + 1),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) u_v_axis (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .step_i     (h_wrap),
        .clear_i    (axis_clear),
        .cnt_o      (v_cnt),
        .wrap_o     (v_wrap),
        .sync_d_o   (v_sync_d),
        .active_d_o (v_active_d)
    );

    // -----------------------------------------------------------------------
    // Run/stop controller. All transitions are qualified by tick; v_wrap
    // already implies tick and a scanning state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && !en) begin
                    state_d = v_wrap ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (tick && en) begin
                    state_d = RUN;
                end else if (v_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    // -----------------------------------------------------------------------
    // Markers and decoded outputs, computed from next-state values and
    // registered alongside the counters.
    // -----------------------------------------------------------------------
    logic       starting;
    logic       scanning_d;
    logic       line_start_d;
    logic       frame_start_d;
    logic       hsync_d;
    logic       vsync_d;
    logic       blank_d;
    logic [7:0] frame_cnt_d;

    logic       pix_tick_q;
    logic       line_start_q;
    logic       frame_start_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       blank_q;
    logic       running_q;
    logic [7:0] frame_cnt_q;

    assign scanning_d = (state_d != IDLE);

    // Leaving IDLE keeps (x,y) at (0,0), so it counts as a line and frame
    // start even though the counters themselves do not move.
    assign starting      = (state_q == IDLE) && scanning_d;
    assign line_start_d  = starting || (h_wrap && scanning_d);
    assign frame_start_d = starting || (v_wrap && scanning_d);
    assign frame_cnt_d   = frame_cnt_q + 8'(frame_start_d);

    assign hsync_d = !scanning_d || !h_sync_d;
    assign vsync_d = !scanning_d || !v_sync_d;
    assign blank_d = !scanning_d || !(h_active_d && v_active_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            running_q     <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            pix_tick_q    <= tick;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            running_q     <= scanning_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA scan datapath: owns the horizontal and vertical pixel counters and steps them on a pixel-rate enable derived from the system clock. It decodes sync, blanking and frame/line markers, and gates scanning with a frame-aligned run/stop handshake. It sits between the board clock and the pixel generator/VGA pins, replacing free-running counter chaining with one controlled timing source.

## Interface

Parameters:
- N, 9: counter MSB index; x/y are N+1 bits.
- CLK_DIV, 2: clk cycles per pixel tick (≥1); 50 MHz → 25 MHz.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segments in pixels (total 800).
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segments in lines (total 525).

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- pix_tick  out  1  one-clk pulse every CLK_DIV clks.
- x  out  N+1  horizontal position 0..H_TOTAL-1.
- y  out  N+1  vertical position 0..V_TOTAL-1.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- blank  out  1  high outside the active area or when idle.
- line_start  out  1  one-clk pulse when x becomes 0 while running.
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0) while running.
- running  out  1  scanning state.
- frame_cnt  out  8  frames started, modulo 256.

## Operation

- Divider: div counts 0..CLK_DIV-1 on every clk; pix_tick=1 when div==CLK_DIV-1. It free-runs whether or not the controller is running. With CLK_DIV=1, pix_tick stays high.
- FSM states IDLE, RUN, DRAIN.
  - IDLE → RUN on a tick with en=1.
  - RUN → DRAIN on a tick with en=0.
  - DRAIN → RUN on a tick with en=1.
  - RUN/DRAIN → IDLE on the tick where (x,y)=(H_TOTAL-1,V_TOTAL-1) and en=0.
  - A stop request therefore always completes the current frame. The wrap tick with en=1 continues into the next frame with no gap.
- Counters advance only on ticks in RUN/DRAIN.
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0.
  - In IDLE, x=y=0.
  - Widths: H_TOTAL-1 and V_TOTAL-1 must fit in N+1 bits; x/y never exceed these values.
- Decode from the next-state counters, registered so outputs align with x/y:
  - hsync=0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
  - blank=1 iff x≥H_ACTIVE or y≥V_ACTIVE or state=IDLE.
  - In IDLE, hsync=vsync=1.
- Start from IDLE: on the start tick, running→1, (x,y) stays (0,0), and frame_start and line_start pulse.
- frame_cnt increments with each frame_start and wraps 255→0.
- running=1 in RUN and DRAIN.

## Timing

- Reset values (asserted asynchronously; reset mid-frame aborts immediately):
  - state=IDLE, div=0, x=0, y=0.
  - hsync=1, vsync=1, blank=1, running=0.
  - pix_tick=0, line_start=0, frame_start=0, frame_cnt=0.
- First pix_tick occurs CLK_DIV clks after rst_n deasserts.
- All outputs change on the clk edge of the tick, and x/y/sync/blank are mutually consistent in the same cycle: zero skew, one-register latency from counter update.
- line_start and frame_start are one clk wide, not one tick wide.
- en is sampled only on tick cycles. A pulse on en between ticks is ignored.
- Line = H_TOTAL ticks; frame = H_TOTAL·V_TOTAL ticks (default 420000 ticks = 840000 clks).

## Structure

- Shared package vga_pkg holds:
  - default timing constants;
  - derived H_TOTAL/V_TOTAL and sync start/end localparams;
  - state enum typedef vga_state_t {IDLE, RUN, DRAIN}.
- One sub-module, vga_axis_seq, instantiated twice (horizontal and vertical). It is a parameterised wrapping counter with step/clear inputs, wrap output and sync-window decode. The top holds the divider, FSM, pulses and frame_cnt.

## Test plan

- Reset: hold rst_n=0 with en=1 → all outputs at reset values. Release → first pix_tick at clk 2; running=1 at that tick and frame_start pulses once.
- Horizontal timing with defaults: after start, hsync falls when x=656 and rises when x=752. blank falls at x=0 and rises at x=640. line_start pulses every 1600 clks.
- Vertical timing with reduced parameters (H 8/1/2/1, V 6/1/1/1): vsync is low exactly on y=7. The frame is 12·9=108 ticks, and frame_cnt goes 0→1→2.
- Drain: drop en at tick (x=3,y=2) of a reduced frame → running stays 1 until the wrap tick, then goes 0 with hsync=vsync=1, blank=1, x=y=0. No frame_start follows.
- Re-arm: raise en during DRAIN before the wrap → continuous scanning, frame_start at wrap, no IDLE cycle. Raise en only on a non-tick cycle while in IDLE → no start.
- Mid-frame reset: assert rst_n=0 asynchronously at x=300,y=100 → outputs go to reset values without waiting for a clk edge. Restart behaves as a fresh start.
